// File: rtl/qmu_arbiter.sv
// Round-robin arbiter sharing one non-stalling qmu between N_REQ requesters, with credit-limited
// issue, in-order tag tracking and a show-ahead response FIFO. Optional stats: QMU_ARB_STATS_EN.
module qmu_arbiter #(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  localparam int ID_W       = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ*DATA_W-1:0] req_data,
  input  logic [N_REQ*2-1:0]      req_mode,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    qmu_valid_in,
  output logic [DATA_W-1:0]       qmu_data_in,
  output logic [1:0]              qmu_mode,
  input  logic                    qmu_valid_out,
  input  logic [DATA_W-1:0]       qmu_data_out,
  output logic                    rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    err
`ifdef QMU_ARB_STATS_EN
  ,
  output logic [N_REQ*16-1:0]     grant_cnt
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int USED_W = CNT_W + 1;

  logic [ID_W-1:0]        r_rr_ptr;
  logic [CNT_W-1:0]       r_inflight;
  logic [CNT_W-1:0]       r_rsp_cnt;
  logic [ID_W-1:0]        r_tag_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_tag_wr;
  logic [PTR_W-1:0]       r_tag_rd;
  logic [ID_W+DATA_W-1:0] r_rsp_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_rsp_wr;
  logic [PTR_W-1:0]       r_rsp_rd;
  logic                   r_err;
  logic                   r_qvalid;
  logic [DATA_W-1:0]      r_qdata;
  logic [1:0]             r_qmode;

  logic                   w_found;
  logic [ID_W-1:0]        w_winner;
  logic [USED_W-1:0]      w_used;
  logic                   w_can_issue;
  logic                   w_accept;
  logic                   w_ret;
  logic                   w_err_evt;
  logic                   w_pop;

  // Search starts at the round-robin pointer and wraps modulo N_REQ.
  always_comb begin
    int unsigned v_idx;
    v_idx    = 0;
    w_found  = 1'b0;
    w_winner = '0;
    for (int k = 0; k < N_REQ; k++) begin
      v_idx = (int'(r_rr_ptr) + k) % N_REQ;
      if (!w_found && req_valid[ID_W'(v_idx)]) begin
        w_found  = 1'b1;
        w_winner = ID_W'(v_idx);
      end
    end
  end

  assign w_used      = {1'b0, r_inflight} + {1'b0, r_rsp_cnt};
  assign w_can_issue = w_used < USED_W'(FIFO_DEPTH);
  assign w_accept    = w_found && w_can_issue;
  assign w_ret       = qmu_valid_out && (r_inflight != '0);
  assign w_err_evt   = qmu_valid_out && (r_inflight == '0);
  assign w_pop       = (r_rsp_cnt != '0) && rsp_ready;

  // Grant is masked during reset so every output reads 0 immediately.
  always_comb begin
    req_ready = '0;
    if (w_accept && !rst) begin
      req_ready[w_winner] = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr_ptr <= '0;
      r_qvalid <= 1'b0;
      r_qdata  <= '0;
      r_qmode  <= '0;
      r_err    <= 1'b0;
    end else begin
      r_qvalid <= w_accept;
      if (w_accept) begin
        r_qdata  <= req_data[w_winner*DATA_W +: DATA_W];
        r_qmode  <= req_mode[w_winner*2 +: 2];
        r_rr_ptr <= (w_winner == ID_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
      end
      if (w_err_evt) begin
        r_err <= 1'b1;
      end
    end
  end

  // Tag FIFO: occupancy equals the in-flight count, so no separate counter is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_inflight <= '0;
      r_tag_wr   <= '0;
      r_tag_rd   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_tag_mem[i] <= '0;
      end
    end else begin
      if (w_accept) begin
        r_tag_mem[r_tag_wr] <= w_winner;
        r_tag_wr            <= r_tag_wr + 1'b1;
      end
      if (w_ret) begin
        r_tag_rd <= r_tag_rd + 1'b1;
      end
      if (w_accept && !w_ret) begin
        r_inflight <= r_inflight + 1'b1;
      end else if (!w_accept && w_ret) begin
        r_inflight <= r_inflight - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_cnt <= '0;
      r_rsp_wr  <= '0;
      r_rsp_rd  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_rsp_mem[i] <= '0;
      end
    end else begin
      if (w_ret) begin
        r_rsp_mem[r_rsp_wr] <= {r_tag_mem[r_tag_rd], qmu_data_out};
        r_rsp_wr            <= r_rsp_wr + 1'b1;
      end
      if (w_pop) begin
        r_rsp_rd <= r_rsp_rd + 1'b1;
      end
      if (w_ret && !w_pop) begin
        r_rsp_cnt <= r_rsp_cnt + 1'b1;
      end else if (!w_ret && w_pop) begin
        r_rsp_cnt <= r_rsp_cnt - 1'b1;
      end
    end
  end

  assign qmu_valid_in       = r_qvalid;
  assign qmu_data_in        = r_qdata;
  assign qmu_mode           = r_qmode;
  assign rsp_valid          = r_rsp_cnt != '0;
  assign {rsp_id, rsp_data} = r_rsp_mem[r_rsp_rd];
  assign err                = r_err;

`ifdef QMU_ARB_STATS_EN
  logic [15:0] r_grant_cnt [N_REQ];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_REQ; i++) begin
        r_grant_cnt[i] <= '0;
      end
    end else if (w_accept) begin
      r_grant_cnt[w_winner] <= r_grant_cnt[w_winner] + 16'd1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      grant_cnt[i*16 +: 16] = r_grant_cnt[i];
    end
  end
`endif

endmodule
